song_sequencer: RTL
===================

Name: song_sequencer

Overview:
Front-end sequencer for the piano's playback path. It selects one of 8 stored songs with next/prev buttons, starts and stops playback with a play button, and steps through the selected song's note ROM at a fixed tempo. It drives current_track and playing to the LED control stage, and drives note/note_on to the tone generator.

Parameters:
TICKS_PER_BEAT, 12_500_000, clk cycles per beat (8 beats/s at 100 MHz); must be >= 2.
GAP_TICKS, 1_250_000, clk cycles of silence inserted between consecutive notes; must be >= 1.
STEP_W, 5, width of the step index; each song has at most 2^STEP_W entries.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
btn_next  in  1  debounced level; a rising edge selects the next track
btn_prev  in  1  debounced level; a rising edge selects the previous track
btn_play  in  1  debounced level; a rising edge toggles start/stop
current_track  out  4  selected track, 0..7; bit 3 is always 0
playing  out  1  high while a song is in progress
note  out  4  current note code; 0 = rest
note_on  out  1  high while a non-rest note is sounding
step  out  STEP_W  index of the current song entry

Behaviour:
- Reset is asynchronous, active-high, clock is clk. Reset values:
  - current_track=0, playing=0, note=0, note_on=0, step=0.
  - State IDLE, all counters 0, edge-detect history registers 0.
- Edge detect:
  - Each button has a registered previous value.
  - A press is in_now & ~in_prev, and is acted on in the same cycle it is detected.
  - A held button produces exactly one press.
- ROM entry is 8 bits: [3:0] note code, [5:4] duration in beats minus 1, [7:6] reserved (0).
  - note 4'hF is the END marker.
  - The ROM is synchronous with 1-cycle read latency; its address is {current_track[2:0], step}.
- States: IDLE, LOAD, SOUND, GAP.
- IDLE:
  - next press increments current_track, wrapping 7->0.
  - prev press decrements current_track, wrapping 0->7.
  - next and prev pressed together: no change.
  - play press: step<=0, playing<=1, go to LOAD. Play has priority; a simultaneous next/prev is ignored.
- LOAD:
  - Lasts exactly 1 cycle while ROM data settles. Decoding happens on the LOAD->next edge.
  - If the entry is END, go to the end-of-song action.
  - Otherwise: note<=entry note, note_on<=(note!=0), beat counter loaded for (dur+1)*TICKS_PER_BEAT cycles, go to SOUND.
- SOUND:
  - Lasts exactly (dur+1)*TICKS_PER_BEAT cycles.
  - On expiry: note_on<=0, note<=0, go to GAP.
- GAP:
  - Lasts GAP_TICKS cycles.
  - On expiry: if step == all-ones, go to the end-of-song action; else step<=step+1 and go to LOAD. step never wraps.
- End-of-song action: playing<=0, note<=0, note_on<=0, step<=0, go to IDLE (unless the optional feature is enabled).
- Play press in LOAD/SOUND/GAP: stop. On the next edge: playing=0, note_on=0, note=0, step=0, state IDLE. The current note is cut immediately.
- next/prev presses are ignored while playing=1. current_track is stable for the whole song.
- Reset mid-song: outputs return to reset values immediately (asynchronous).

Optional Feature:
SEQ_AUTO_ADVANCE_EN
- Defined: the end-of-song action instead does current_track<=(current_track+1) mod 8, step<=0, playing stays 1, go to LOAD. Playback continues through tracks indefinitely until a play press stops it.
- Undefined: the end-of-song action is exactly as described in Behaviour.

Decomposition:
- Shared package piano_pkg holds:
  - state enum seq_state_t {IDLE, LOAD, SOUND, GAP}
  - NOTE_REST=4'h0, NOTE_END=4'hF
  - ROM field offsets/widths NOTE_LSB=0, NOTE_W=4, DUR_LSB=4, DUR_W=2
  - NUM_TRACKS=8
- One sub-module, song_rom:
  - Synchronous read, 1-cycle latency, 8 x 2^STEP_W x 8-bit, initialised from song tables.
  - The bench can also drive it through a hex-file override.

Test Plan:
All scenarios use TICKS_PER_BEAT=4 and GAP_TICKS=1.
- Reset, then 9 next presses -> current_track steps 1..7, 0, 1; one prev from 0 -> 7; holding btn_next for 20 cycles -> exactly one increment.
- Track 2 ROM {note 5 dur 1, note 0 dur 0, END}, play press -> playing=1 next edge. Then 1 LOAD cycle; note=5, note_on=1 for 8 cycles; 1 gap cycle; note=0, note_on=0 for 4 cycles; gap; LOAD; playing=0, step=0.
- Play press during first SOUND cycle of note 5 -> next edge: playing=0, note_on=0, state IDLE; no further ROM reads.
- next and play pressed in the same IDLE cycle at track 3 -> playback starts on track 3, current_track stays 3; next presses during playback leave current_track unchanged.
- ROM with no END marker (all 32 entries note 1 dur 0) -> exactly 32 notes, step reaches 31, then playing=0 and step=0.
- SEQ_AUTO_ADVANCE_EN defined, track 7 song ends -> current_track=0, playing stays 1, step=0, LOAD follows immediately.

Source files
------------

// File: rtl/piano_pkg.sv
// piano_pkg: shared types and constants for the piano playback path.
//   seq_state_t    - song sequencer states (IDLE, LOAD, SOUND, GAP)
//   NOTE_REST/END  - special note codes (rest, end-of-song marker)
//   NOTE_*/DUR_*   - song ROM entry field layout
//   NUM_TRACKS     - number of stored songs
//   default_fields - built-in song tables, note/duration fields only
package piano_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SOUND,
        GAP
    } seq_state_t;

    localparam logic [3:0] NOTE_REST = 4'h0;
    localparam logic [3:0] NOTE_END  = 4'hF;

    localparam int unsigned NOTE_LSB   = 0;
    localparam int unsigned NOTE_W     = 4;
    localparam int unsigned DUR_LSB    = 4;
    localparam int unsigned DUR_W      = 2;
    localparam int unsigned NUM_TRACKS = 8;
    localparam int unsigned TRACK_W    = 3;

    // Built-in songs: track t has 4+t notes, then END. The reserved entry
    // bits [7:6] are always zero, so only the note/duration fields are kept.
    function automatic logic [NOTE_W+DUR_W-1:0] default_fields(
        input logic [TRACK_W-1:0] track,
        input int unsigned        idx
    );
        int unsigned t;
        t = 32'(track);
        if (idx < 4 + t) begin
            return {DUR_W'(idx % 4), NOTE_W'(((t * 3 + idx) % 14) + 1)};
        end
        return {DUR_W'(0), NOTE_END};
    endfunction

endpackage

// File: rtl/song_sequencer_if.sv
// song_sequencer_if: button inputs and playback outputs of song_sequencer.
//   btn_next/btn_prev/btn_play - debounced button levels (into the sequencer)
//   current_track, playing     - to the LED control stage
//   note, note_on, step        - to the tone generator
// Modports: master drives the buttons, slave is the sequencer side.
interface song_sequencer_if #(
    parameter int unsigned STEP_W = 5
);
    logic              btn_next;
    logic              btn_prev;
    logic              btn_play;
    logic [3:0]        current_track;
    logic              playing;
    logic [3:0]        note;
    logic              note_on;
    logic [STEP_W-1:0] step;

    modport master (
        output btn_next, btn_prev, btn_play,
        input  current_track, playing, note, note_on, step
    );

    modport slave (
        input  btn_next, btn_prev, btn_play,
        output current_track, playing, note, note_on, step
    );
endinterface

// File: rtl/song_rom.sv
// song_rom: note ROM, NUM_TRACKS x 2^STEP_W entries, synchronous read with
// one cycle of latency.
//   clk    - read clock
//   addr   - {track, step}
//   fields - {duration-1, note} of the addressed entry
// ROM_OVERRIDE selects a caller-supplied image (ROM_INIT, 8 bits per entry,
// entry i at bits [8*i +: 8]) instead of the built-in song tables.
module song_rom
    import piano_pkg::*;
#(
    parameter int unsigned                         STEP_W       = 5,
    parameter logic [NUM_TRACKS*(2**STEP_W)*8-1:0] ROM_INIT     = '0,
    parameter bit                                  ROM_OVERRIDE = 1'b0
) (
    input  logic                      clk,
    input  logic [TRACK_W+STEP_W-1:0] addr,
    output logic [NOTE_W+DUR_W-1:0]   fields
);
    logic [NOTE_W+DUR_W-1:0] fields_d;
    logic [NOTE_W+DUR_W-1:0] fields_q;

    always_comb begin
        fields_d = '0;
        if (ROM_OVERRIDE) begin
            fields_d = ROM_INIT[{addr, 3'b000} +: (NOTE_W + DUR_W)];
        end else begin
            fields_d = default_fields(addr[TRACK_W+STEP_W-1:STEP_W],
                                      32'(addr[STEP_W-1:0]));
        end
    end

    always_ff @(posedge clk) begin
        fields_q <= fields_d;
    end

    assign fields = fields_q;
endmodule

// File: rtl/song_sequencer.sv
// song_sequencer: selects one of 8 songs with next/prev, starts/stops with
// play, and steps through the song ROM at a fixed tempo.
//   clk, rst - clock, asynchronous active-high reset
//   bus      - song_sequencer_if.slave: buttons in; current_track, playing,
//              note, note_on, step out
// Build option SEQ_AUTO_ADVANCE_EN: at end of song, continue with the next
// track instead of returning to IDLE.
module song_sequencer
    import piano_pkg::*;
#(
    parameter int unsigned                         TICKS_PER_BEAT = 12_500_000,
    parameter int unsigned                         GAP_TICKS      = 1_250_000,
    parameter int unsigned                         STEP_W         = 5,
    parameter logic [NUM_TRACKS*(2**STEP_W)*8-1:0] ROM_INIT       = '0,
    parameter bit                                  ROM_OVERRIDE   = 1'b0
) (
    input logic              clk,
    input logic              rst,
    song_sequencer_if.slave  bus
);
    localparam int unsigned CNT_W =
        $clog2((1 << DUR_W) * TICKS_PER_BEAT + GAP_TICKS);

    seq_state_t          state_q, state_d;
    logic [TRACK_W-1:0]  track_q, track_d;
    logic                playing_q, playing_d;
    logic [NOTE_W-1:0]   note_q, note_d;
    logic                note_on_q, note_on_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                btn_next_q, btn_next_d;
    logic                btn_prev_q, btn_prev_d;
    logic                btn_play_q, btn_play_d;

    logic [NOTE_W+DUR_W-1:0] rom_fields;
    logic [NOTE_W-1:0]       rom_note;
    logic [DUR_W-1:0]        rom_dur;
    logic                    next_press, prev_press, play_press;
    logic                    do_stop, do_end;

    // The ROM is addressed with the next track/step so the entry for a LOAD
    // cycle is already on rom_fields during that cycle and can be decoded on
    // the LOAD exit edge.
    song_rom #(
        .STEP_W       (STEP_W),
        .ROM_INIT     (ROM_INIT),
        .ROM_OVERRIDE (ROM_OVERRIDE)
    ) u_rom (
        .clk    (clk),
        .addr   ({track_d, step_d}),
        .fields (rom_fields)
    );

    assign rom_note   = rom_fields[NOTE_LSB +: NOTE_W];
    assign rom_dur    = rom_fields[DUR_LSB +: DUR_W];
    assign next_press = bus.btn_next & ~btn_next_q;
    assign prev_press = bus.btn_prev & ~btn_prev_q;
    assign play_press = bus.btn_play & ~btn_play_q;

    always_comb begin
        state_d    = state_q;
        track_d    = track_q;
        playing_d  = playing_q;
        note_d     = note_q;
        note_on_d  = note_on_q;
        step_d     = step_q;
        cnt_d      = cnt_q;
        btn_next_d = bus.btn_next;
        btn_prev_d = bus.btn_prev;
        btn_play_d = bus.btn_play;
        do_stop    = 1'b0;
        do_end     = 1'b0;

        case (state_q)
            IDLE: begin
                if (play_press) begin
                    step_d    = '0;
                    playing_d = 1'b1;
                    state_d   = LOAD;
                end else if (next_press && !prev_press) begin
                    track_d = track_q + TRACK_W'(1);
                end else if (prev_press && !next_press) begin
                    track_d = track_q - TRACK_W'(1);
                end
            end
            LOAD: begin
                if (play_press) begin
                    do_stop = 1'b1;
                end else if (rom_note == NOTE_END) begin
                    do_end = 1'b1;
                end else begin
                    note_d    = rom_note;
                    note_on_d = (rom_note != NOTE_REST);
                    cnt_d     = CNT_W'((32'(rom_dur) + 32'd1) * TICKS_PER_BEAT - 32'd1);
                    state_d   = SOUND;
                end
            end
            SOUND: begin
                if (play_press) begin
                    do_stop = 1'b1;
                end else if (cnt_q == '0) begin
                    note_d    = NOTE_REST;
                    note_on_d = 1'b0;
                    cnt_d     = CNT_W'(GAP_TICKS - 1);
                    state_d   = GAP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            GAP: begin
                if (play_press) begin
                    do_stop = 1'b1;
                end else if (cnt_q == '0) begin
                    if (step_q == '1) begin
                        do_end = 1'b1;
                    end else begin
                        step_d  = step_q + STEP_W'(1);
                        state_d = LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_stop) begin
            state_d   = IDLE;
            playing_d = 1'b0;
            note_d    = NOTE_REST;
            note_on_d = 1'b0;
            step_d    = '0;
            cnt_d     = '0;
        end

        if (do_end) begin
`ifdef SEQ_AUTO_ADVANCE_EN
            track_d   = track_q + TRACK_W'(1);
            state_d   = LOAD;
            playing_d = 1'b1;
`else
            state_d   = IDLE;
            playing_d = 1'b0;
`endif
            note_d    = NOTE_REST;
            note_on_d = 1'b0;
            step_d    = '0;
            cnt_d     = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            track_q    <= '0;
            playing_q  <= 1'b0;
            note_q     <= '0;
            note_on_q  <= 1'b0;
            step_q     <= '0;
            cnt_q      <= '0;
            btn_next_q <= 1'b0;
            btn_prev_q <= 1'b0;
            btn_play_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            track_q    <= track_d;
            playing_q  <= playing_d;
            note_q     <= note_d;
            note_on_q  <= note_on_d;
            step_q     <= step_d;
            cnt_q      <= cnt_d;
            btn_next_q <= btn_next_d;
            btn_prev_q <= btn_prev_d;
            btn_play_q <= btn_play_d;
        end
    end

    assign bus.current_track = {1'b0, track_q};
    assign bus.playing       = playing_q;
    assign bus.note          = note_q;
    assign bus.note_on       = note_on_q;
    assign bus.step          = step_q;
endmodule
